// File: rtl/high_pass_ve.sv
// DC-removal high-pass: data_o = data_i minus an exponentially tracked baseline, with a
// preload / fast-acquire / track start-up sequencer. Define HP_BLANK_EN to zero data_o until settled.
module high_pass_ve #(
   parameter int                     WIDTH         = 16,
   parameter int                     alpha_WIDTH   = 32,
   parameter logic [alpha_WIDTH-1:0] ALPHA_FAST    = 32'h1000_0000,
   parameter int                     SETTLE_CYCLES = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic [alpha_WIDTH-1:0] alpha_i,
   input  logic                   restart_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   settled_o
);

   localparam int ACC_W = WIDTH + alpha_WIDTH + 1;

   localparam logic [1:0] S_PRELOAD = 2'd0;
   localparam logic [1:0] S_ACQUIRE = 2'd1;
   localparam logic [1:0] S_TRACK   = 2'd2;

   logic [1:0]              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [WIDTH-1:0]        data_o_q, data_o_d;
   logic                    settled_q, settled_d;

   logic signed [WIDTH:0]   baseline;
   logic signed [WIDTH:0]   diff;
   logic [alpha_WIDTH-1:0]  coef_sel;
   logic signed [ACC_W-1:0] diff_x, coef_x, prod;

   function automatic logic [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
      if (v[WIDTH] != v[WIDTH-1])
         return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         return v[WIDTH-1:0];
   endfunction

   // Baseline is the integer part of acc (floor); the slice equals acc >>> alpha_WIDTH.
   assign baseline = acc_q[ACC_W-1:alpha_WIDTH];
   assign diff     = $signed({data_i[WIDTH-1], data_i}) - baseline;
   assign coef_sel = (state_q == S_ACQUIRE) ? ALPHA_FAST : alpha_i;

   // Exact product fits ACC_W bits: |diff| <= 2^WIDTH and coef < 2^alpha_WIDTH.
   assign diff_x = {{(ACC_W-WIDTH-1){diff[WIDTH]}}, diff};
   assign coef_x = $signed({{(ACC_W-alpha_WIDTH){1'b0}}, coef_sel});
   assign prod   = diff_x * coef_x;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      data_o_d  = data_o_q;
      settled_d = settled_q;
      if (restart_i) begin
         state_d   = S_PRELOAD;
         settled_d = 1'b0;
         data_o_d  = '0;
      end else begin
         case (state_q)
            S_PRELOAD: begin
               acc_d     = {data_i[WIDTH-1], data_i, {alpha_WIDTH{1'b0}}};
               data_o_d  = '0;
               cnt_d     = '0;
               settled_d = 1'b0;
               state_d   = S_ACQUIRE;
            end
            S_ACQUIRE: begin
               acc_d    = acc_q + prod;
               data_o_d = sat(diff);
               cnt_d    = cnt_q + 16'd1;
               if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
                  state_d   = S_TRACK;
                  settled_d = 1'b1;
               end
            end
            S_TRACK: begin
               acc_d     = acc_q + prod;
               data_o_d  = sat(diff);
               settled_d = 1'b1;
            end
            default: begin
               state_d   = S_PRELOAD;
               settled_d = 1'b0;
               data_o_d  = '0;
            end
         endcase
      end
`ifdef HP_BLANK_EN
      if (!settled_d)
         data_o_d = '0;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_PRELOAD;
         acc_q     <= '0;
         cnt_q     <= '0;
         data_o_q  <= '0;
         settled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         data_o_q  <= data_o_d;
         settled_q <= settled_d;
      end
   end

   assign data_o    = data_o_q;
   assign settled_o = settled_q;

endmodule

// File: tb/tb_high_pass_ve.sv
// Scoreboard bench for high_pass_ve: a reference model queues the expected registered
// outputs for every driven cycle; a negedge monitor pops and compares them.
module tb_high_pass_ve;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] data_i = '0;
   logic [31:0] alpha_i = '0;
   logic        restart_i = 1'b0;
   logic [15:0] data_o;
   logic        settled_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] o;
      logic        s;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state
   longint m_acc = 0;
   int     m_cnt = 0;
   int     m_state = 0;
   logic   m_set = 1'b0;
   logic [15:0] m_out = '0;

   high_pass_ve dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .alpha_i   (alpha_i),
      .restart_i (restart_i),
      .data_o    (data_o),
      .settled_o (settled_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (data_o !== e.o || settled_o !== e.s) begin
            errors++;
            $display("FAIL scoreboard t=%0t data_o=%0d settled_o=%b required data_o=%0d settled_o=%b",
                     $time, $signed(data_o), settled_o, $signed(e.o), e.s);
         end
      end
   end

   function automatic logic [15:0] sat16(input longint v);
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   // Drive one cycle, advance the model, queue its expectation, return after the monitor ran.
   task automatic drive(input int d, input logic [31:0] a, input logic rs, input logic rt);
      longint base, diff, coef;
      data_i    = d[15:0];
      alpha_i   = a;
      restart_i = rs;
      rst_i     = rt;
      if (rt) begin
         m_state = 0; m_acc = 0; m_cnt = 0; m_set = 1'b0; m_out = '0;
      end else if (rs) begin
         m_state = 0; m_set = 1'b0; m_out = '0;
      end else begin
         base = m_acc >>> 32;
         diff = longint'(d) - base;
         case (m_state)
            0: begin
               m_acc = longint'(d) <<< 32;
               m_cnt = 0; m_set = 1'b0; m_out = '0; m_state = 1;
            end
            1: begin
               coef  = 64'h1000_0000;
               m_acc = m_acc + diff * coef;
               m_out = sat16(diff);
               if (m_cnt == 15) begin
                  m_state = 2; m_set = 1'b1;
               end
               m_cnt++;
            end
            default: begin
               coef  = longint'(a);
               m_acc = m_acc + diff * coef;
               m_out = sat16(diff);
               m_set = 1'b1;
            end
         endcase
`ifdef HP_BLANK_EN
         if (!m_set) m_out = '0;
`endif
      end
      sb_q.push_back({m_out, m_set});
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(123, 32'h0, 1'b0, 1'b1);
      drive(-77, 32'h0, 1'b1, 1'b1);
      checks++;
      if (data_o !== 16'd0 || settled_o !== 1'b0) begin
         errors++;
         $display("FAIL reset data_o=%0d settled_o=%b required 0/0", $signed(data_o), settled_o);
      end
   endtask

   task automatic test_settle();
      for (int i = 0; i < 20; i++) begin
         drive(1000, 32'h0, 1'b0, 1'b0);
         checks++;
         if (data_o !== 16'd0 || settled_o !== (i >= 16)) begin
            errors++;
            $display("FAIL settle edge=%0d data_o=%0d settled_o=%b required 0/%b",
                     i + 1, $signed(data_o), settled_o, (i >= 16));
         end
      end
   endtask

   // Restart, preload 0 and let acquisition finish so the baseline is exactly 0 in TRACK.
   task automatic settle_at_zero();
      drive(0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) drive(0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_step();
      int req[5] = '{1000, 500, 250, 125, 63};
      settle_at_zero();
      for (int i = 0; i < 8; i++) begin
         drive(1000, 32'h8000_0000, 1'b0, 1'b0);
         if (i < 5) begin
            checks++;
            if ($signed(data_o) !== 16'(req[i])) begin
               errors++;
               $display("FAIL step idx=%0d data_o=%0d required %0d", i, $signed(data_o), req[i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      drive(-32768, 32'h0, 1'b1, 1'b0);
      drive(-32768, 32'h0, 1'b0, 1'b0);
      drive(32767, 32'h0, 1'b0, 1'b0);
      checks++;
      if (data_o !== 16'h7FFF) begin
         errors++;
         $display("FAIL sat_pos data_o=%0d required 32767", $signed(data_o));
      end
      drive(32767, 32'h0, 1'b0, 1'b0);
      drive(32767, 32'h0, 1'b1, 1'b0);
      drive(32767, 32'h0, 1'b0, 1'b0);
      drive(-32768, 32'h0, 1'b0, 1'b0);
      checks++;
      if (data_o !== 16'h8000) begin
         errors++;
         $display("FAIL sat_neg data_o=%0d required -32768", $signed(data_o));
      end
   endtask

   task automatic test_alpha_zero();
      settle_at_zero();
      for (int i = 0; i < 20; i++) begin
         drive(i, 32'h0, 1'b0, 1'b0);
         checks++;
         if (data_o !== 16'(i)) begin
            errors++;
            $display("FAIL alpha_zero i=%0d data_o=%0d required %0d", i, $signed(data_o), i);
         end
      end
   endtask

   task automatic test_alpha_max();
      for (int i = 0; i < 4; i++) drive(5000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(-3000 + $urandom_range(0, 50), 32'hFFFF_FFFF, 1'b0, 1'b0);
   endtask

   task automatic test_restart();
      drive(500, 32'h4000_0000, 1'b1, 1'b0);
      checks++;
      if (settled_o !== 1'b0 || data_o !== 16'd0) begin
         errors++;
         $display("FAIL restart data_o=%0d settled_o=%b required 0/0", $signed(data_o), settled_o);
      end
      for (int i = 0; i < 17; i++) begin
         drive(500, 32'h4000_0000, 1'b0, 1'b0);
         checks++;
         if (data_o !== 16'd0 || settled_o !== (i == 16)) begin
            errors++;
            $display("FAIL resettle edge=%0d data_o=%0d settled_o=%b required 0/%b",
                     i + 1, $signed(data_o), settled_o, (i == 16));
         end
      end
      drive(900, 32'h4000_0000, 1'b0, 1'b0);
      drive(900, 32'h4000_0000, 1'b1, 1'b1);
      checks++;
      if (data_o !== 16'd0 || settled_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_and_restart data_o=%0d settled_o=%b required 0/0", $signed(data_o), settled_o);
      end
   endtask

   task automatic test_blank();
      logic [15:0] req;
      drive(0, 32'h0, 1'b0, 1'b1);
      drive(0, 32'h0, 1'b0, 1'b0);
      drive(200, 32'h0, 1'b0, 1'b0);
`ifdef HP_BLANK_EN
      req = 16'd0;
`else
      req = 16'd200;
`endif
      checks++;
      if (data_o !== req) begin
         errors++;
         $display("FAIL blank_first data_o=%0d required %0d", $signed(data_o), req);
      end
      for (int i = 0; i < 18; i++) drive(200, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_settle();
      test_step();
      test_saturation();
      test_alpha_zero();
      test_alpha_max();
      test_restart();
      test_blank();
      drive(0, 32'h0, 1'b0, 1'b0);
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/high_pass_ve.md
Name: high_pass_ve

Overview:
- Complementary high-pass (DC-removal) block: data_o = data_i minus an exponentially tracked baseline.
- Sits in front of the feedback path wherever low_pass_v2 feeds it, to strip offset drift from the ADC stream.
- Adds a start-up sequencer: preload, then a fast-acquire phase, then normal tracking, so offset transients do not reach downstream logic.

Parameters:
- WIDTH, 16: sample width, signed two's complement.
- alpha_WIDTH, 32: width of alpha; alpha is an unsigned fraction alpha/2^alpha_WIDTH.
- ALPHA_FAST, 32'h1000_0000: alpha used during ACQUIRE (1/16 at default width); same format as alpha_i.
- SETTLE_CYCLES, 16: number of ACQUIRE cycles; legal range 1..65535.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- data_i  in  WIDTH  signed input sample, one per clock
- alpha_i  in  alpha_WIDTH  tracking coefficient used in TRACK; sampled every cycle
- restart_i  in  1  synchronous pulse; re-runs the start-up sequence
- data_o  out  WIDTH  signed high-passed sample, registered
- settled_o  out  1  high while in TRACK

Behaviour:
- Clock and reset:
  - One clock, clk_i. rst_i is synchronous and active-high.
  - Reset values: data_o=0, settled_o=0, acc=0, counter=0, state=PRELOAD.
- Accumulator:
  - acc: signed, WIDTH+alpha_WIDTH+1 bits, holding baseline·2^alpha_WIDTH.
  - baseline = acc >>> alpha_WIDTH (floor), WIDTH+1 bits.
- Update rule in ACQUIRE/TRACK:
  - diff = data_i − baseline, WIDTH+1 bits, signed.
  - acc <= acc + diff·a, where a = ALPHA_FAST in ACQUIRE and a = alpha_i in TRACK.
  - a is zero-extended to signed before multiplying. The product is full precision, with no rounding.
- Output:
  - data_o <= sat(data_i − baseline), using the pre-update baseline.
  - Saturation range is [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Latency from data_i to data_o is 1 cycle.
- FSM:
  - PRELOAD, one cycle:
    - acc <= data_i <<< alpha_WIDTH; data_o <= 0; counter <= 0; settled_o <= 0.
    - Next state: ACQUIRE.
  - ACQUIRE:
    - Update with ALPHA_FAST; counter increments.
    - When counter == SETTLE_CYCLES−1: next state TRACK and settled_o <= 1.
  - TRACK:
    - Update with alpha_i; stays in TRACK indefinitely.
    - alpha_i changes take effect on the very next edge, with no re-acquire.
- restart_i:
  - High in any state → next state PRELOAD, settled_o <= 0, data_o <= 0.
  - The PRELOAD cycle that follows samples data_i as usual.
  - restart_i held high keeps the block in PRELOAD.
- Simultaneous events:
  - rst_i wins over restart_i.
  - Reset mid-ACQUIRE or mid-TRACK discards acc and the counter immediately.
- Boundary conditions:
  - alpha_i = 0 freezes the baseline, so data_o = data_i − held baseline.
  - alpha_i near 2^alpha_WIDTH gives a baseline that follows the input within one cycle.
  - The baseline is a convex combination of samples, so acc never overflows.
- Timing: settled_o rises after the 17th rising edge with rst_i low (1 PRELOAD + 16 ACQUIRE, at defaults).

Optional Feature:
- Macro: HP_BLANK_EN.
- Defined: data_o is forced to 0 whenever settled_o is 0 (PRELOAD and ACQUIRE); accumulator behaviour is unchanged.
- Undefined: data_o carries the residual during ACQUIRE and is 0 only in PRELOAD.

Test Plan:
- Reset release, data_i constant 1000 → data_o = 0 every cycle; settled_o rises after edge 17 and stays high.
- Settled, alpha_i = 32'h8000_0000, baseline 0, data_i steps 0→1000 → data_o sequence 1000, 500, 250, 125, 63, 32 …
- Preload with data_i = −32768, then data_i = 32767 → data_o saturates at 32767 (no wrap); symmetric negative case gives −32768.
- In TRACK, alpha_i = 0, data_i ramps +1 per cycle from 0 (baseline 0) → data_o equals data_i exactly, with no baseline drift.
- restart_i pulse in TRACK, data_i = 500 → settled_o low next cycle, data_o 0, baseline reloads to 500, settled_o high again after 17 edges; rst_i and restart_i asserted together → reset values.
- HP_BLANK_EN defined, baseline preloaded 0, data_i = 200 during ACQUIRE → data_o = 0 until settled_o = 1; undefined → nonzero decaying residual seen in ACQUIRE.
